decoder: RTL and testbench

DECODER -- requirements
Module: decoder

---
 rtl/decoder_pkg.sv | 33 +++
 rtl/decoder_seg_glyph.sv | 25 ++
 rtl/decoder.sv | 71 +++++++
 tb/tb_decoder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// ============================================================================
// Module : decoder_pkg
// Brief  : Shared constants for the seven-segment decoder: glyph table,
//          segment-off pattern and segment bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package decoder_pkg;

  // Segment bit positions within the cathode bus, order {g,f,e,d,c,b,a}
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_W = SEG_G + 1;

  // Active-low encoding: every segment dark
  localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

  localparam logic [SEG_W-1:0] GLYPH_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

`default_nettype wire

// File: rtl/decoder_seg_glyph.sv
// ============================================================================
// Module : seg_glyph
// Brief  : Combinational 4-bit value to active-low 7-segment glyph lookup.
//          Macro DECODER_HEX_EN enables glyphs A..F for values 10..15;
//          without it those values decode to all segments dark.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg_glyph
  import decoder_pkg::*;
(
  input  logic [3:0]       number,
  output logic [SEG_W-1:0] glyph
);

`ifdef DECODER_HEX_EN
  assign glyph = GLYPH_TABLE[number];
`else
  assign glyph = (number > 4'd9) ? SEG_OFF : GLYPH_TABLE[number];
`endif

endmodule

`default_nettype wire

// File: rtl/decoder.sv
// ============================================================================
// Module : decoder
// Brief  : Registered seven-segment digit driver: glyph decode, polarity
//          select, one-hot-low anode decode, blanking. Optional hex glyphs
//          via macro DECODER_HEX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module decoder
  import decoder_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            number,
  input  logic [2:0]            digit_sel,
  input  logic                  blank,
  output logic [SEG_W-1:0]      cathode,
  output logic [NUM_DIGITS-1:0] AN
);

  // Dark pattern in the configured output polarity
  localparam logic [SEG_W-1:0] c_cat_off = SEG_ACTIVE_LOW ? SEG_OFF : ~SEG_OFF;

  logic [SEG_W-1:0]      w_glyph;
  logic                  w_in_range;
  logic [SEG_W-1:0]      cathode_d, cathode_q;
  logic [NUM_DIGITS-1:0] an_d, an_q;

  seg_glyph u_seg_glyph (
    .number (number),
    .glyph  (w_glyph)
  );

  assign w_in_range = ({29'd0, digit_sel} < NUM_DIGITS);

  always_comb begin
    an_d = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!blank && (digit_sel == i[2:0])) begin
        an_d[i] = 1'b0;
      end
    end
  end

  always_comb begin
    cathode_d = c_cat_off;
    if (!blank && w_in_range) begin
      cathode_d = SEG_ACTIVE_LOW ? w_glyph : ~w_glyph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cathode_q <= c_cat_off;
      an_q      <= '1;
    end else begin
      cathode_q <= cathode_d;
      an_q      <= an_d;
    end
  end

  assign cathode = cathode_q;
  assign AN      = an_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder.sv
// ============================================================================
// Module : tb_decoder
// Brief  : Self-checking bench for decoder; three instances cover the
//          default build, NUM_DIGITS=4 and SEG_ACTIVE_LOW=0.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] number;
  logic [2:0] digit_sel;
  logic       blank;

  logic [6:0] cat8, cat4, cat_ah;
  logic [7:0] an8, an_ah;
  logic [3:0] an4;

  int checks = 0;
  int errors = 0;

  decoder #(.NUM_DIGITS(8), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .number(number), .digit_sel(digit_sel),
    .blank(blank), .cathode(cat8), .AN(an8)
  );

  decoder #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
    .clk(clk), .rst_n(rst_n), .number(number), .digit_sel(digit_sel),
    .blank(blank), .cathode(cat4), .AN(an4)
  );

  decoder #(.NUM_DIGITS(8), .SEG_ACTIVE_LOW(1'b0)) dut_ah (
    .clk(clk), .rst_n(rst_n), .number(number), .digit_sel(digit_sel),
    .blank(blank), .cathode(cat_ah), .AN(an_ah)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] num;
    logic [2:0] sel;
    logic       blk;
    logic [6:0] cat;
    logic [7:0] an;
  } vec_t;

  vec_t vecs [40];
  int   nvec;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] n, input logic [2:0] s, input logic b,
                     input logic [6:0] c, input logic [7:0] a);
    vecs[nvec] = '{num: n, sel: s, blk: b, cat: c, an: a};
    nvec++;
  endtask

  // Expected values for the 4-digit and active-high instances
  task automatic chk_all(input string tag, input vec_t v);
    logic [6:0] c4;
    logic [3:0] a4;
    c4 = (v.sel < 3'd4) ? v.cat : 7'b1111111;
    a4 = (v.sel < 3'd4) ? v.an[3:0] : 4'b1111;
    chk({tag, "_cat8"},  {1'b0, cat8},   {1'b0, v.cat});
    chk({tag, "_an8"},   an8,            v.an);
    chk({tag, "_cat4"},  {1'b0, cat4},   {1'b0, c4});
    chk({tag, "_an4"},   {4'h0, an4},    {4'h0, a4});
    chk({tag, "_catah"}, {1'b0, cat_ah}, {1'b0, ~c4 | (v.sel < 3'd4 ? 7'b0 : ~v.cat)});
    chk({tag, "_anah"},  an_ah,          v.an);
  endtask

  logic [6:0] hex_c;
  vec_t       prev;

  initial begin
    nvec = 0;
    // Decimal sweep on digit 0
    add(4'd0, 3'd0, 1'b0, 7'b1000000, 8'b11111110);
    add(4'd1, 3'd0, 1'b0, 7'b1111001, 8'b11111110);
    add(4'd2, 3'd0, 1'b0, 7'b0100100, 8'b11111110);
    add(4'd3, 3'd0, 1'b0, 7'b0110000, 8'b11111110);
    add(4'd4, 3'd0, 1'b0, 7'b0011001, 8'b11111110);
    add(4'd5, 3'd0, 1'b0, 7'b0010010, 8'b11111110);
    add(4'd6, 3'd0, 1'b0, 7'b0000010, 8'b11111110);
    add(4'd7, 3'd0, 1'b0, 7'b1111000, 8'b11111110);
    add(4'd8, 3'd0, 1'b0, 7'b0000000, 8'b11111110);
    add(4'd9, 3'd0, 1'b0, 7'b0010000, 8'b11111110);
    // Hex values on digit 1
`ifdef DECODER_HEX_EN
    add(4'd10, 3'd1, 1'b0, 7'b0001000, 8'b11111101);
    add(4'd11, 3'd1, 1'b0, 7'b0000011, 8'b11111101);
    add(4'd12, 3'd1, 1'b0, 7'b1000110, 8'b11111101);
    add(4'd13, 3'd1, 1'b0, 7'b0100001, 8'b11111101);
    add(4'd14, 3'd1, 1'b0, 7'b0000110, 8'b11111101);
    add(4'd15, 3'd1, 1'b0, 7'b0001110, 8'b11111101);
`else
    for (int h = 10; h < 16; h++) add(h[3:0], 3'd1, 1'b0, 7'b1111111, 8'b11111101);
`endif
    // Anode walk with number 3
    add(4'd3, 3'd0, 1'b0, 7'b0110000, 8'b11111110);
    add(4'd3, 3'd1, 1'b0, 7'b0110000, 8'b11111101);
    add(4'd3, 3'd2, 1'b0, 7'b0110000, 8'b11111011);
    add(4'd3, 3'd3, 1'b0, 7'b0110000, 8'b11110111);
    add(4'd3, 3'd4, 1'b0, 7'b0110000, 8'b11101111);
    add(4'd3, 3'd5, 1'b0, 7'b0110000, 8'b11011111);
    add(4'd3, 3'd6, 1'b0, 7'b0110000, 8'b10111111);
    add(4'd3, 3'd7, 1'b0, 7'b0110000, 8'b01111111);
    // Blanking overrides any number / digit, then recovery
    add(4'd8, 3'd2, 1'b1, 7'b1111111, 8'b11111111);
    add(4'd1, 3'd5, 1'b1, 7'b1111111, 8'b11111111);
    add(4'd1, 3'd5, 1'b0, 7'b1111001, 8'b11011111);
    add(4'd1, 3'd2, 1'b0, 7'b1111001, 8'b11111011);

    // Asynchronous reset before any clock edge
    rst_n = 1'b1; number = 4'd8; digit_sel = 3'd0; blank = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_cat8",  {1'b0, cat8},   8'h7F);
    chk("rst_an8",   an8,            8'hFF);
    chk("rst_an4",   {4'h0, an4},    8'h0F);
    chk("rst_catah", {1'b0, cat_ah}, 8'h00);
    repeat (2) @(posedge clk);
    #1 chk("rst_hold_cat8", {1'b0, cat8}, 8'h7F);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_cat8", {1'b0, cat8}, 8'h00);
    chk("rel_an8",  an8,          8'hFE);
    prev = '{num: 4'd8, sel: 3'd0, blk: 1'b0, cat: 7'b0000000, an: 8'b11111110};

    // Table-driven vectors; outputs must not move before the clock edge
    for (int i = 0; i < nvec; i++) begin
      @(negedge clk);
      number = vecs[i].num; digit_sel = vecs[i].sel; blank = vecs[i].blk;
      #1;
      chk($sformatf("hold%0d_cat8", i), {1'b0, cat8}, {1'b0, prev.cat});
      @(posedge clk); #1;
      chk_all($sformatf("v%0d", i), vecs[i]);
      prev = vecs[i];
    end

    // Reset mid-operation darkens immediately, without a clock edge
    @(negedge clk);
    number = 4'd8; digit_sel = 3'd2; blank = 1'b0;
    @(posedge clk); #1;
    chk("pre_cat8", {1'b0, cat8}, 8'h00);
    chk("pre_an8",  an8,          8'hFB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_cat8",  {1'b0, cat8},   8'h7F);
    chk("mid_an8",   an8,            8'hFF);
    chk("mid_an4",   {4'h0, an4},    8'h0F);
    chk("mid_catah", {1'b0, cat_ah}, 8'h00);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rec_cat8", {1'b0, cat8}, 8'h00);
    chk("rec_an4",  {4'h0, an4},  8'h0B);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
